// File: rtl/ifu_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The master modport is the fetch unit's side; slave is the memory/decode environment.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic [DATA_WIDTH-1:0] imem_resp_data;
    logic                  imem_resp_err;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [ADDR_WIDTH-1:0] dnpc;
    logic                  fetch_err;
    logic [31:0]           fetch_count;

    modport master (
        output imem_req_valid, imem_req_addr, pc, inst, inst_valid, fetch_err, fetch_count,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready, dnpc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, pc, inst, inst_valid, fetch_err, fetch_count,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready, dnpc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one word fetch in flight, instruction held for decode
// until consumed, next address taken from decode's dnpc. Faults are terminal.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic         clk,
    input  logic         rst_n,
    ifu_fetch_if.master  bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, ERR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] inst_reg;
    logic                  inst_valid_reg;
    logic                  fetch_err_reg;
    logic [31:0]           fetch_count_reg;

    // Request is gated by rst_n so nothing is offered to memory while reset is held.
    assign bus.imem_req_valid = (state == REQ) && rst_n;
    assign bus.imem_req_addr  = pc_reg;
    assign bus.pc             = pc_reg;
    assign bus.inst           = inst_reg;
    assign bus.inst_valid     = inst_valid_reg;
    assign bus.fetch_err      = fetch_err_reg;
    assign bus.fetch_count    = fetch_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= REQ;
            pc_reg          <= RESET_PC;
            inst_reg        <= '0;
            inst_valid_reg  <= 1'b0;
            fetch_err_reg   <= 1'b0;
            fetch_count_reg <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (bus.imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (bus.imem_resp_err) begin
                            state         <= ERR;
                            fetch_err_reg <= 1'b1;
                        end else begin
                            state          <= HOLD;
                            inst_reg       <= bus.imem_resp_data;
                            inst_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.inst_ready) begin
                        // pc follows dnpc even when misaligned so the faulting target is visible.
                        pc_reg          <= bus.dnpc;
                        inst_valid_reg  <= 1'b0;
                        fetch_count_reg <= fetch_count_reg + 32'd1;
                        if (bus.dnpc[1:0] == 2'b00) begin
                            state <= REQ;
                        end else begin
                            state         <= ERR;
                            fetch_err_reg <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state          <= ERR;
                    inst_valid_reg <= 1'b0;
                    fetch_err_reg  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed handshake/fault/reset scenarios, then a randomized
// run scored against an address-to-word memory model and a queue of expected instructions.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    bit   mon_on = 1'b0;
    exp_t sbq[$];

    // Random-phase model state
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    bit          busy;
    int          lat;
    logic [31:0] maddr;

    ifu_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ifu_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.dnpc            = '0;
    endtask

    // Leaves rst_n low at a negedge after two reset clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    // One cycle of randomized memory and decode behaviour, with model updates.
    task automatic drive_random();
        logic [31:0] r;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        if (busy) begin
            if (lat == 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(maddr);
                busy = 1'b0;
            end else begin
                lat--;
            end
        end
        bus.imem_req_ready = ($urandom_range(0, 3) != 0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_pc);
            busy  = 1'b1;
            maddr = bus.imem_req_addr;
            lat   = $urandom_range(0, 2);
        end
        r = $urandom();
        bus.dnpc       = {r[31:2], 2'b00};
        bus.inst_ready = ($urandom_range(0, 1) == 1);
        if (bus.inst_valid && bus.inst_ready) begin
            exp_pc  = {r[31:2], 2'b00};
            exp_cnt = exp_cnt + 32'd1;
            sbq.push_back('{pc: exp_pc, inst: mem_word(exp_pc), cnt: exp_cnt});
        end
    endtask

    // Monitor: each newly presented instruction is matched against the scoreboard head.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (bus.inst_valid && !prev) begin
                    if (sbq.size() == 0) begin
                        check("sb_unexpected_inst", {32'd0, bus.pc}, 64'hffff_ffff_ffff_ffff);
                    end else begin
                        e = sbq.pop_front();
                        pops++;
                        check("sb_pc", bus.pc, e.pc);
                        check("sb_inst", bus.inst, e.inst);
                        check("sb_count", bus.fetch_count, e.cnt);
                    end
                end
                prev = bus.inst_valid;
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_fetch_err", bus.fetch_err, 1'b0);
        check("rst_count", bus.fetch_count, 32'd0);

        // Basic fetch: accept at cycle 0, response at 1, present at 2, next request at 3
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.dnpc           = 32'h8000_0004;
        #1;
        check("c0_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8000_0000});
        @(negedge clk);
        check("c1_req_valid", bus.imem_req_valid, 1'b0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0000_0413;
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        check("c2_inst_valid", bus.inst_valid, 1'b1);
        check("c2_inst", bus.inst, 32'h0000_0413);
        check("c2_pc", bus.pc, 32'h8000_0000);
        @(negedge clk);
        check("c3_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8000_0004});
        check("c3_count", bus.fetch_count, 32'd1);
        check("c3_inst_valid", bus.inst_valid, 1'b0);

        // Request back-pressure: request must stay up with a stable address
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8000_0004});
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        // In WAIT: a stray inst_ready with a bogus dnpc must be ignored
        bus.dnpc = 32'h8000_0010;
        for (int i = 0; i < 3; i++) begin
            check("wait_idle", {bus.imem_req_valid, bus.inst_valid, bus.pc},
                  {1'b0, 1'b0, 32'h8000_0004});
            check("wait_count", bus.fetch_count, 32'd1);
            @(negedge clk);
        end
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hcafe_0093;
        bus.inst_ready      = 1'b0;
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;

        // Decode back-pressure: everything held in HOLD
        for (int i = 0; i < 5; i++) begin
            check("hold_ctrl", {bus.inst_valid, bus.imem_req_valid, bus.pc},
                  {1'b1, 1'b0, 32'h8000_0004});
            check("hold_data", {bus.inst, bus.fetch_count}, {32'hcafe_0093, 32'd1});
            @(negedge clk);
        end

        // Misaligned dnpc: pc takes it, fault raised, no request
        bus.inst_ready = 1'b1;
        bus.dnpc       = 32'h8000_0102;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        check("mis_pc", bus.pc, 32'h8000_0102);
        check("mis_err", bus.fetch_err, 1'b1);
        check("mis_count", bus.fetch_count, 32'd2);
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.imem_resp_valid = ($urandom_range(0, 1) == 1);
            bus.imem_resp_data  = $urandom();
            @(negedge clk);
            check("mis_terminal", {bus.imem_req_valid, bus.inst_valid, bus.fetch_err}, 3'b001);
        end

        // Reset clears a faulted unit
        do_reset();
        check("clr_count", bus.fetch_count, 32'd0);
        check("clr_err_pc", {bus.fetch_err, bus.pc}, {1'b0, RESET_PC});

        // Response error while waiting
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_err   = 1'b1;
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        check("rerr_flag", {bus.fetch_err, bus.inst_valid}, 2'b10);
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rerr_terminal", {bus.imem_req_valid, bus.inst_valid, bus.fetch_err}, 3'b001);
        end

        // Reset during WAIT; a late response after release must be dropped
        do_reset();
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rw_req_in_reset", bus.imem_req_valid, 1'b0);
        check("rw_state", {bus.pc, bus.fetch_count}, {RESET_PC, 32'd0});
        rst_n = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hdead_beef;
        #1;
        check("rw_fresh_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, RESET_PC});
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        check("rw_late_resp", {bus.imem_req_valid, bus.inst_valid, bus.fetch_err}, 3'b100);
        check("rw_inst", bus.inst, 32'd0);

        // Randomized run against the scoreboard
        do_reset();
        exp_pc  = RESET_PC;
        exp_cnt = 32'd0;
        busy    = 1'b0;
        lat     = 0;
        maddr   = '0;
        sbq.delete();
        sbq.push_back('{pc: RESET_PC, inst: mem_word(RESET_PC), cnt: 32'd0});
        rst_n  = 1'b1;
        mon_on = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            drive_random();
        end
        mon_on = 1'b0;
        check("rand_progress", {63'd0, pops >= 100}, 64'd1);
        check("rand_no_fault", bus.fetch_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
